// File: rtl/bus_request_arbiter.sv
// Round-robin arbiter sharing one upstream bus port between NUM_REQ requesters.
// Grants bursts of up to MAX_BURST beats and drives a registered vld/addr/data stage.
module bus_request_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_vld,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_rdy,
    input  logic                       bus_rdy,
    output logic                       vld,
    output logic [ADDR_W-1:0]          addr,
    output logic [DATA_W-1:0]          data,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       busy
);
    // Handshakes: a requester beat transfers on a rising clk edge where req_vld[i] && req_rdy[i];
    // an output beat transfers where vld && bus_rdy, and vld/addr/data hold while vld && !bus_rdy.
    localparam int GNT_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [GNT_W-1:0]   r_gnt_id, w_gnt_nxt;
    logic [GNT_W-1:0]   r_last_gnt, w_last_nxt;
    logic [CNT_W-1:0]   r_burst_cnt, w_cnt_nxt;
    logic [GNT_W-1:0]   w_pick;
    logic               w_any;
    logic               w_owner_vld;
    logic               w_out_free;
    logic               w_accept;
    logic [ADDR_W-1:0]  w_owner_addr;
    logic [DATA_W-1:0]  w_owner_data;
    logic               r_vld;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_data;

    assign w_owner_vld  = req_vld[r_gnt_id];
    assign w_owner_addr = req_addr[r_gnt_id*ADDR_W +: ADDR_W];
    assign w_owner_data = req_data[r_gnt_id*DATA_W +: DATA_W];
    assign w_out_free   = !r_vld || bus_rdy;
    assign w_accept     = (r_state == S_OWN) && w_owner_vld && w_out_free;

    // Scan starts just above the previous owner so every requester is reached within NUM_REQ grants.
    always_comb begin : scan
        logic [GNT_W-1:0] v_cand;
        w_pick = '0;
        w_any  = 1'b0;
        v_cand = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            v_cand = GNT_W'((int'(r_last_gnt) + k) % NUM_REQ);
            if (!w_any && req_vld[v_cand]) begin
                w_any  = 1'b1;
                w_pick = v_cand;
            end
        end
    end

    always_comb begin
        req_rdy = '0;
        if (r_state == S_OWN && w_out_free) begin
            req_rdy[r_gnt_id] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt_id;
        w_last_nxt  = r_last_gnt;
        w_cnt_nxt   = r_burst_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_OWN;
                    w_gnt_nxt   = w_pick;
                    w_cnt_nxt   = '0;
                end
            end
            S_OWN: begin
                if (w_accept) begin
                    w_cnt_nxt = r_burst_cnt + 1'b1;
                end
                // Owner dropping valid releases even while the output stage is stalled.
                if (!w_owner_vld || (w_accept && r_burst_cnt == CNT_W'(MAX_BURST - 1))) begin
                    w_state_nxt = S_IDLE;
                    w_last_nxt  = r_gnt_id;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_gnt_id    <= '0;
            r_last_gnt  <= GNT_W'(NUM_REQ - 1);
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt_id    <= w_gnt_nxt;
            r_last_gnt  <= w_last_nxt;
            r_burst_cnt <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else if (w_out_free) begin
            r_vld  <= w_accept;
            r_addr <= w_accept ? w_owner_addr : '0;
            r_data <= w_accept ? w_owner_data : '0;
        end
    end

    assign vld    = r_vld;
    assign addr   = r_addr;
    assign data   = r_data;
    assign gnt_id = r_gnt_id;
    assign busy   = (r_state == S_OWN);

endmodule

// File: tb/tb_bus_request_arbiter.sv
// Self-checking bench for bus_request_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural reference model.
module tb_bus_request_arbiter;
    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int MB = 4;
    localparam int GW = 2;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_vld;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_rdy;
    logic            bus_rdy;
    logic            vld;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
    logic [GW-1:0]   gnt_id;
    logic            busy;

    logic [AW-1:0] r_a [N];
    logic [DW-1:0] r_d [N];

    int checks = 0;
    int errors = 0;

    // Reference model state: owner index or -1 when arbitrating.
    int            m_own  = -1;
    int            m_last = N - 1;
    int            m_gnt  = 0;
    int            m_cnt  = 0;
    int            m_acc  = -1;
    bit            m_vld  = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    logic [AW+DW-1:0] exp_q[$];

    logic          obs_vld  = 0;
    logic          obs_busy = 0;
    logic [AW-1:0] obs_addr = '0;
    logic [DW-1:0] obs_data = '0;
    int            gnt_log[$];

    bus_request_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_addr(req_addr), .req_data(req_data),
        .req_rdy(req_rdy), .bus_rdy(bus_rdy), .vld(vld), .addr(addr), .data(data),
        .gnt_id(gnt_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] m_rdy(input bit br);
        if (m_own >= 0 && (!m_vld || br)) return N'(1) << m_own;
        return '0;
    endfunction

    task automatic model_edge();
        bit free;
        int acc;
        logic [AW+DW-1:0] b;
        if (rst) begin
            m_own = -1; m_last = N - 1; m_gnt = 0; m_cnt = 0; m_acc = -1;
            m_vld = 0; m_addr = '0; m_data = '0;
            exp_q.delete();
            return;
        end
        if (obs_vld && bus_rdy) begin
            check("beat_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() > 0) begin
                b = exp_q.pop_front();
                check("beat_payload", 32'({obs_addr, obs_data}), 32'(b));
            end
        end
        free = !m_vld || bus_rdy;
        acc  = -1;
        if (m_own >= 0 && req_vld[m_own] && free) acc = m_own;
        if (free) begin
            m_vld = (acc >= 0);
            if (acc >= 0) begin
                m_addr = r_a[acc];
                m_data = r_d[acc];
                exp_q.push_back({r_a[acc], r_d[acc]});
            end else begin
                m_addr = '0;
                m_data = '0;
            end
        end
        if (m_own < 0) begin
            for (int k = 1; k <= N; k++) begin
                if (m_own < 0 && req_vld[(m_last + k) % N]) m_own = (m_last + k) % N;
            end
            if (m_own >= 0) begin
                m_gnt = m_own;
                m_cnt = 0;
            end
        end else begin
            if (acc >= 0) m_cnt++;
            if (!req_vld[m_own] || m_cnt == MB) begin
                m_last = m_own;
                m_own  = -1;
            end
        end
        m_acc = acc;
    endtask

    // One clock: inputs already set by the caller; check combinational ready, clock, check registers.
    task automatic step();
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = r_a[i];
            req_data[i*DW +: DW] = r_d[i];
        end
        #1;
        check("req_rdy", 32'(req_rdy), 32'(m_rdy(bus_rdy)));
        @(posedge clk);
        model_edge();
        #1;
        check("vld", 32'(vld), 32'(m_vld));
        check("addr", 32'(addr), 32'(m_addr));
        check("data", 32'(data), 32'(m_data));
        check("gnt_id", 32'(gnt_id), 32'(m_gnt));
        check("busy", 32'(busy), (m_own >= 0) ? 32'd1 : 32'd0);
        if (busy && !obs_busy) gnt_log.push_back(int'(gnt_id));
        obs_vld  = vld;
        obs_busy = busy;
        obs_addr = addr;
        obs_data = data;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_vld = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        req_vld = '0;
        bus_rdy = 1'b1;
        for (int i = 0; i < N; i++) begin
            r_a[i] = '0;
            r_d[i] = '0;
        end
        req_addr = '0;
        req_data = '0;
        @(posedge clk);
        #1;

        // Reset held two cycles, then idle
        step();
        step();
        rst = 1'b0;
        repeat (10) begin
            step();
            check("t1_vld", 32'(vld), 32'd0);
            check("t1_rdy", 32'(req_rdy), 32'd0);
        end

        // Single requester: 4 beats then one bubble
        r_a[0] = 8'h10; r_d[0] = 16'hA5A5; req_vld = 4'b0001; bus_rdy = 1'b1;
        n = 0;
        repeat (10) begin
            step();
            if (obs_vld) begin
                n++;
                check("t2_addr", 32'(obs_addr), 32'h10);
            end
        end
        check("t2_beats", 32'(n), 32'd8);

        // Round-robin from reset
        do_reset();
        r_a[1] = 8'h30; r_a[2] = 8'h50; r_a[3] = 8'h70;
        req_vld = 4'b1111;
        gnt_log.delete();
        repeat (25) begin
            step();
            if (obs_vld && obs_addr == 8'h50) check("t3_addr50_owner", 32'(gnt_id), 32'd2);
        end
        check("t3_ngrants", 32'(gnt_log.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < gnt_log.size()) check("t3_order", 32'(gnt_log[k]), 32'(k % N));
        end

        // Back-pressure holds the output beat
        do_reset();
        r_a[1] = 8'h3F; r_d[1] = 16'h1234; req_vld = 4'b0010;
        step();
        step();
        check("t4_first_beat", 32'(addr), 32'h3F);
        bus_rdy = 1'b0;
        repeat (3) begin
            step();
            check("t4_hold_vld", 32'(vld), 32'd1);
            check("t4_hold_addr", 32'(addr), 32'h3F);
            check("t4_hold_data", 32'(data), 32'h1234);
            check("t4_stall_rdy", 32'(req_rdy), 32'd0);
        end
        bus_rdy = 1'b1;
        repeat (6) step();

        // Early release of req3 hands over to req0
        do_reset();
        r_a[3] = 8'h77; r_a[0] = 8'h11; req_vld = 4'b1000;
        gnt_log.delete();
        n = 0;
        step();
        req_vld = 4'b1001;
        repeat (2) begin
            step();
            if (obs_vld && obs_addr == 8'h77) n++;
        end
        req_vld = 4'b0001;
        repeat (4) begin
            step();
            if (obs_vld && obs_addr == 8'h77) n++;
        end
        check("t5_req3_beats", 32'(n), 32'd2);
        check("t5_ngrants", (gnt_log.size() >= 2) ? 32'd1 : 32'd0, 32'd1);
        if (gnt_log.size() >= 2) begin
            check("t5_first", 32'(gnt_log[0]), 32'd3);
            check("t5_next", 32'(gnt_log[1]), 32'd0);
        end

        // Reset mid-burst with a stalled beat
        do_reset();
        r_a[0] = 8'h80; r_d[0] = 16'hBEEF; req_vld = 4'b0001;
        step();
        step();
        check("t6_pre_addr", 32'(addr), 32'h80);
        bus_rdy = 1'b0;
        rst = 1'b1;
        step();
        check("t6_vld", 32'(vld), 32'd0);
        check("t6_addr", 32'(addr), 32'd0);
        check("t6_data", 32'(data), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        bus_rdy = 1'b1;
        req_vld = 4'b1111;
        gnt_log.delete();
        repeat (2) step();
        check("t6_regrant", (gnt_log.size() > 0) ? 32'(gnt_log[0]) : 32'hFFFF, 32'd0);

        // Random traffic against the model
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < N; i++) begin
                if (req_vld[i] && m_acc != i) begin
                    if ($urandom_range(0, 9) == 0) req_vld[i] = 1'b0;
                end else begin
                    req_vld[i] = ($urandom_range(0, 99) < 60);
                    r_a[i] = AW'($urandom);
                    r_d[i] = DW'($urandom);
                end
            end
            bus_rdy = ($urandom_range(0, 99) < 70);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_request_arbiter.md
Name: bus_request_arbiter

Overview:
Round-robin arbiter that shares the single upstream port of bus_switching_controller between NUM_REQ requesters. Each requester offers addr/data beats on a valid/ready handshake. The arbiter grants one requester at a time for a burst of up to MAX_BURST beats. It drives a registered vld/addr/data stage straight into the switch, and honours downstream back-pressure via bus_rdy.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 8, address width
DATA_W, 16, data width
MAX_BURST, 4, max beats accepted per grant before forced release (1..16)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
req_vld  input  NUM_REQ  per-requester beat valid
req_addr  input  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  packed data, requester i at [i*DATA_W +: DATA_W]
req_rdy  output  NUM_REQ  per-requester ready, combinational, one-hot or zero
bus_rdy  input  1  downstream accepts the current output beat
vld  output  1  registered beat valid to bus_switching_controller
addr  output  ADDR_W  registered beat address, 0 when vld=0
data  output  DATA_W  registered beat data, 0 when vld=0
gnt_id  output  clog2(NUM_REQ)  current/last owner index
busy  output  1  1 while in OWN state

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; vld=0; addr=0; data=0; gnt_id=0; busy=0; burst_cnt=0; last_gnt=NUM_REQ-1, so requester 0 has first priority.
- Reset mid-burst discards the in-flight output beat and the grant. No beat survives reset.
- FSM IDLE:
  - If any req_vld is high, pick the first i with req_vld[i]=1 scanning from last_gnt+1 upward, modulo NUM_REQ.
  - Next state OWN; gnt_id<=i; burst_cnt<=0.
  - req_rdy is all-zero in IDLE, so there is a 1-cycle arbitration bubble per grant.
- FSM OWN:
  - req_rdy[gnt_id] = (!vld || bus_rdy). All other req_rdy bits are 0.
  - Accept = req_vld[gnt_id] && req_rdy[gnt_id]. On accept, burst_cnt increments.
- Output stage: when (!vld || bus_rdy), load vld<=accept.
  - On accept, addr/data take the owner's addr/data; otherwise addr/data load 0.
  - When vld && !bus_rdy, vld/addr/data hold unchanged.
- Release OWN->IDLE, with last_gnt<=gnt_id, when either:
  - (a) accept occurs with burst_cnt==MAX_BURST-1, i.e. the MAX_BURST-th beat; or
  - (b) req_vld[gnt_id]==0 in any OWN cycle, including while stalled.
- On release, an already-loaded output beat still completes normally; the output stage is independent of the FSM.
- Latency: accepted beat appears on vld/addr/data on the next cycle. Grant occurs 1 cycle after req_vld is seen in IDLE.
- Throughput: with bus_rdy=1 the owner moves 1 beat/cycle. For a single requester, the max sustained rate is MAX_BURST beats per MAX_BURST+1 cycles.
- Requesters must hold addr/data stable while req_vld=1 && req_rdy=0. The arbiter does not check this.
- Requests from non-owners are ignored until the next IDLE arbitration. No starvation: every requester is granted within NUM_REQ grants.
- gnt_id holds its last value in IDLE. busy=1 exactly when state==OWN.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, all req_vld=0 → vld=0, addr=00, data=0000, busy=0, req_rdy=0000 for 10 cycles.
2. Single requester burst: req_vld=0001 continuously, req0 addr=10/data=A5A5, bus_rdy=1 → grant after 1 cycle; 4 beats on vld (addr=10) in consecutive cycles; then 1 bubble cycle, then the next burst.
3. Round-robin: req_vld=1111, bus_rdy=1 → grant order gnt_id 0,1,2,3,0. Each burst is 4 beats; req2 addr=50 appears on addr only during gnt_id=2 beats.
4. Back-pressure: owner req1 (addr=3F, data=1234), bus_rdy=0 for 3 cycles after the first beat → vld=1, addr=3F, data=1234 held; req_rdy[1]=0 during stall; burst_cnt unchanged; resumes when bus_rdy=1.
5. Early release: req3 drops req_vld after 2 beats, with req0 pending → OWN->IDLE; next grant to req0 (scan from 0 after last_gnt=3); only 2 beats from req3 seen.
6. Reset mid-burst: rst=1 while vld=1, addr=80, bus_rdy=0 → next cycle vld=0, addr=00, data=0000, busy=0; after rst=0, requester 0 is granted first.
